// File: rtl/bucket_rotation_ctrl_if.sv
// Bus between the bucket rotation controller and its surroundings:
// register-block configuration, datapath arbitration input, scrub
// write port and pointer/status outputs.
interface bucket_rotation_ctrl_if #(
  parameter int INDEX_WIDTH  = 14,
  parameter int BITS_SHIFT   = 7,
  parameter int PERIOD_WIDTH = 16,
  parameter int ADDR_WIDTH   = 8
);
  logic                    enable;
  logic [PERIOD_WIDTH-1:0] period;
  logic                    mem_busy;
  logic [INDEX_WIDTH-1:0]  cur_index;
  logic [BITS_SHIFT-1:0]   cur_bucket;
  logic                    clr_wr_en;
  logic [ADDR_WIDTH-1:0]   clr_addr;
  logic [INDEX_WIDTH-1:0]  clr_mask;
  logic                    rotate;
  logic                    busy;
  logic [31:0]             rot_count;
  logic [31:0]             stall_count;

  modport master (
    output enable, period, mem_busy,
    input  cur_index, cur_bucket, clr_wr_en, clr_addr, clr_mask,
           rotate, busy, rot_count, stall_count
  );

  modport slave (
    input  enable, period, mem_busy,
    output cur_index, cur_bucket, clr_wr_en, clr_addr, clr_mask,
           rotate, busy, rot_count, stall_count
  );
endinterface

// File: rtl/bucket_rotation_ctrl.sv
// Time-base controller for the latency bucket array. Advances a one-hot
// bucket pointer every programmed period, scrubbing the bucket column
// being entered across the whole bucket memory before each advance.
// Optional statistics counters: define BUCKET_CTRL_STATS_EN.
module bucket_rotation_ctrl #(
  parameter int INDEX_WIDTH  = 14,
  parameter int BITS_SHIFT   = 7,
  parameter int PERIOD_WIDTH = 16,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  bucket_rotation_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLEAR   = 2'd1,
    ADVANCE = 2'd2
  } state_t;

  state_t                  r_state;
  logic [INDEX_WIDTH-1:0]  r_cur_index;
  logic [INDEX_WIDTH-1:0]  r_clr_mask;
  logic [BITS_SHIFT-1:0]   r_cur_bucket;
  logic [PERIOD_WIDTH-1:0] r_tick_cnt;
  logic [ADDR_WIDTH-1:0]   r_addr_cnt;
  logic                    r_rotate;
  logic                    r_busy;

  logic [INDEX_WIDTH-1:0]  w_next_index;
  logic                    w_run;
  logic                    w_tick_done;
  logic                    w_last_addr;
  logic                    w_in_clear;

  // Next bucket: rotate left by one with wrap from the top bit to bit 0.
  assign w_next_index = {r_cur_index[INDEX_WIDTH-2:0], r_cur_index[INDEX_WIDTH-1]};
  assign w_run        = bus.enable && (bus.period != '0);
  // >= rather than == so a shortened period never strands the counter.
  assign w_tick_done  = r_tick_cnt >= (bus.period - PERIOD_WIDTH'(1));
  assign w_last_addr  = (r_addr_cnt == '1);
  assign w_in_clear   = (r_state == CLEAR);

  // Rotation FSM: idle countdown, column scrub, single-cycle pointer advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cur_index  <= INDEX_WIDTH'(1);
      r_cur_bucket <= '0;
      r_clr_mask   <= '0;
      r_tick_cnt   <= '0;
      r_addr_cnt   <= '0;
      r_rotate     <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_rotate <= 1'b0;
          if (!w_run) begin
            r_tick_cnt <= '0;
          end else if (w_tick_done) begin
            r_state    <= CLEAR;
            r_tick_cnt <= '0;
            r_addr_cnt <= '0;
            r_clr_mask <= w_next_index;
            r_busy     <= 1'b1;
          end else begin
            r_tick_cnt <= r_tick_cnt + PERIOD_WIDTH'(1);
          end
        end
        CLEAR: begin
          // The datapath has priority on the shared port; stall while it owns it.
          if (!bus.mem_busy) begin
            r_addr_cnt <= r_addr_cnt + ADDR_WIDTH'(1);
            if (w_last_addr) begin
              r_state    <= ADVANCE;
              r_clr_mask <= '0;
              r_rotate   <= 1'b1;
            end
          end
        end
        ADVANCE: begin
          r_state     <= IDLE;
          r_cur_index <= w_next_index;
          r_rotate    <= 1'b0;
          r_busy      <= 1'b0;
          if (r_cur_bucket == BITS_SHIFT'(INDEX_WIDTH - 1)) begin
            r_cur_bucket <= '0;
          end else begin
            r_cur_bucket <= r_cur_bucket + BITS_SHIFT'(1);
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.cur_index  = r_cur_index;
  assign bus.cur_bucket = r_cur_bucket;
  assign bus.clr_addr   = r_addr_cnt;
  assign bus.clr_mask   = r_clr_mask;
  assign bus.rotate     = r_rotate;
  assign bus.busy       = r_busy;
  // Only path from an input: the write strobe yields to the datapath in-cycle.
  assign bus.clr_wr_en  = w_in_clear && !bus.mem_busy;

`ifdef BUCKET_CTRL_STATS_EN
  logic [31:0] r_rot_count;
  logic [31:0] r_stall_count;

  // Rotation and scrub-stall statistics, free-running with natural wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rot_count   <= '0;
      r_stall_count <= '0;
    end else begin
      if (r_state == ADVANCE) begin
        r_rot_count <= r_rot_count + 32'd1;
      end
      if (w_in_clear && bus.mem_busy) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
    end
  end

  assign bus.rot_count   = r_rot_count;
  assign bus.stall_count = r_stall_count;
`else
  assign bus.rot_count   = '0;
  assign bus.stall_count = '0;
`endif

endmodule
